// File: rtl/falc56_bus_master.sv
// FALC56 multiplexed-bus cycle generator: arbitrates via REQ/GNT, then runs one
// ALE/CSn/RDn/WRn access per accepted command and returns read data.
module falc56_bus_master #(
  parameter int ALE_CYCLES    = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       PHY_CLK33_I,
  input  logic       PHY_RST_I,
  input  logic       CMD_VALID_I,
  output logic       CMD_READY_O,
  input  logic       CMD_WR_I,
  input  logic       CMD_CS_I,
  input  logic [7:0] CMD_ADDR_I,
  input  logic [7:0] CMD_WDATA_I,
  output logic       RSP_VALID_O,
  output logic [7:0] RSP_RDATA_O,
  output logic       F56_REQ_O,
  input  logic       F56_GNT_I,
  output logic [7:0] F56_BADD_O,
  output logic       F56_BADD_DIR_O,
  input  logic [7:0] F56_BADD_I,
  output logic       F56_ALE_O,
  output logic       F56_RDn_O,
  output logic       F56_WRn_O,
  output logic [1:0] F56_CSn_O
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_SETUP, S_STROBE, S_RECOVER, S_RELEASE
  } state_t;

  localparam logic [3:0] ALE_LD = 4'(ALE_CYCLES - 1);
  localparam logic [3:0] STB_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HLD_LD = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d, cs_q, cs_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0] rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic       rsp_valid_q, rsp_valid_d, req_q, req_d;
  logic [7:0] badd_q, badd_d;
  logic       dir_q, dir_d, ale_q, ale_d, rdn_q, rdn_d, wrn_q, wrn_d;
  logic [1:0] csn_q, csn_d;
  logic       accept_s;

  assign CMD_READY_O = (state_q == S_IDLE) && !PHY_RST_I;
  assign accept_s    = CMD_VALID_I && CMD_READY_O;

  // Next state, phase counter, command latch and read capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_REQ;
          wr_d    = CMD_WR_I;
          cs_d    = CMD_CS_I;
          addr_d  = CMD_ADDR_I;
          wdata_d = CMD_WDATA_I;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (F56_GNT_I) begin
          state_d = S_ADDR;
          cnt_d   = ALE_LD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = STB_LD;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECOVER;
          cnt_d   = HLD_LD;
          if (!wr_q) begin
            rbuf_d = F56_BADD_I;
          end else begin
            rbuf_d = rbuf_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RELEASE;
          // Read data becomes visible together with the completion pulse
          if (!wr_q) begin
            rdata_d = rbuf_q;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RELEASE: begin
        if (!F56_GNT_I) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pin values for the upcoming state, registered below
  always_comb begin
    rsp_valid_d = (state_d == S_RELEASE) && (state_q != S_RELEASE);
    req_d       = 1'b0;
    badd_d      = 8'h00;
    dir_d       = 1'b0;
    ale_d       = 1'b0;
    rdn_d       = 1'b1;
    wrn_d       = 1'b1;
    csn_d       = 2'b11;
    case (state_d)
      S_REQ: req_d = 1'b1;
      S_ADDR: begin
        req_d  = 1'b1;
        ale_d  = 1'b1;
        badd_d = addr_q;
        dir_d  = 1'b1;
      end
      S_SETUP: begin
        req_d  = 1'b1;
        badd_d = addr_q;
        dir_d  = 1'b1;
      end
      S_STROBE: begin
        req_d = 1'b1;
        csn_d = cs_q ? 2'b01 : 2'b10;
        if (wr_q) begin
          wrn_d  = 1'b0;
          badd_d = wdata_q;
          dir_d  = 1'b1;
        end else begin
          rdn_d = 1'b0;
        end
      end
      S_RECOVER: begin
        req_d = 1'b1;
        if (wr_q) begin
          badd_d = wdata_q;
          dir_d  = 1'b1;
        end else begin
          dir_d = 1'b0;
        end
      end
      default: req_d = 1'b0;
    endcase
  end

  // State and output registers with synchronous reset to idle bus values
  always_ff @(posedge PHY_CLK33_I) begin
    if (PHY_RST_I) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      cs_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rbuf_q      <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      req_q       <= 1'b0;
      badd_q      <= 8'h00;
      dir_q       <= 1'b0;
      ale_q       <= 1'b0;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      csn_q       <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      req_q       <= req_d;
      badd_q      <= badd_d;
      dir_q       <= dir_d;
      ale_q       <= ale_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
      csn_q       <= csn_d;
    end
  end

  assign RSP_VALID_O    = rsp_valid_q;
  assign RSP_RDATA_O    = rdata_q;
  assign F56_REQ_O      = req_q;
  assign F56_BADD_O     = badd_q;
  assign F56_BADD_DIR_O = dir_q;
  assign F56_ALE_O      = ale_q;
  assign F56_RDn_O      = rdn_q;
  assign F56_WRn_O      = wrn_q;
  assign F56_CSn_O      = csn_q;

endmodule

// File: tb/tb_falc56_bus_master.sv
// Directed bench for falc56_bus_master: cycle-exact bus waveform model plus a
// response scoreboard fed at command time and drained on RSP_VALID.
module tb_falc56_bus_master;

  localparam int A = 2;
  localparam int S = 4;
  localparam int H = 1;

  logic       clk = 1'b0;
  logic       rst, valid, wr, cs, gnt;
  logic [7:0] addr, wdata, badd_in;
  logic       ready, rsp_valid, req, dir, ale, rdn, wrn;
  logic [7:0] rdata, badd;
  logic [1:0] csn;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  logic [7:0] last_rd = 8'h00;

  falc56_bus_master #(.ALE_CYCLES(A), .STROBE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .PHY_CLK33_I(clk), .PHY_RST_I(rst),
    .CMD_VALID_I(valid), .CMD_READY_O(ready), .CMD_WR_I(wr), .CMD_CS_I(cs),
    .CMD_ADDR_I(addr), .CMD_WDATA_I(wdata),
    .RSP_VALID_O(rsp_valid), .RSP_RDATA_O(rdata),
    .F56_REQ_O(req), .F56_GNT_I(gnt),
    .F56_BADD_O(badd), .F56_BADD_DIR_O(dir), .F56_BADD_I(badd_in),
    .F56_ALE_O(ale), .F56_RDn_O(rdn), .F56_WRn_O(wrn), .F56_CSn_O(csn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bus_obs();
    return {1'b0, req, ale, csn, rdn, wrn, dir, badd};
  endfunction

  // One access, entered and left at a negedge. gext<0 drops GNT in the second
  // STROBE cycle; otherwise GNT stays high gext cycles past the RELEASE cycle.
  task automatic access(input logic w, input logic c_s, input logic [7:0] ad,
                        input logic [7:0] wd, input logic [7:0] rv,
                        input int gdly, input int gext, input int rst_c);
    int g, a0, st0, rc0, r, ge, idle_c;
    logic addr_ph, setup_ph, strobe, recov, dr;
    logic [1:0] ecsn;
    logic [7:0] bd, prev;
    g      = 1 + gdly;
    a0     = g + 1;
    st0    = a0 + A + 1;
    rc0    = st0 + S;
    r      = rc0 + H;
    ge     = (gext < 0) ? st0 : r + gext;
    idle_c = ((ge + 1 > r) ? ge + 1 : r) + 1;
    prev   = last_rd;
    chk("ready_pre", 16'(ready), 16'd1);
    valid = 1'b1; wr = w; cs = c_s; addr = ad; wdata = wd;
    sb_q.push_back(w ? prev : rv);
    @(negedge clk);
    valid = 1'b0; wr = ~w; cs = ~c_s; addr = ~ad; wdata = ~wd;
    for (int c = 1; c <= idle_c; c++) begin
      addr_ph  = (c >= a0) && (c < a0 + A);
      setup_ph = (c == a0 + A);
      strobe   = (c >= st0) && (c < st0 + S);
      recov    = (c >= rc0) && (c < r);
      ecsn     = strobe ? (c_s ? 2'b01 : 2'b10) : 2'b11;
      dr       = addr_ph || setup_ph || (w && (strobe || recov));
      bd       = (addr_ph || setup_ph) ? ad : ((w && (strobe || recov)) ? wd : 8'h00);
      chk($sformatf("bus c%0d", c), bus_obs(),
          {1'b0, (c < r), addr_ph, ecsn, !(strobe && !w), !(strobe && w), dr, bd});
      chk($sformatf("rsp_valid c%0d", c), 16'(rsp_valid), 16'((c == r) ? 1 : 0));
      chk($sformatf("rdata_hold c%0d", c), 16'(rdata), 16'((!w && c >= r) ? rv : prev));
      chk($sformatf("ready c%0d", c), 16'(ready), 16'((c >= idle_c) ? 1 : 0));
      if (rsp_valid) begin
        if (sb_q.size() > 0) begin
          chk("sb_rdata", 16'(rdata), 16'(sb_q.pop_front()));
        end else begin
          n_vec++;
          n_err++;
          $error("FAIL sb_underflow: observed response expected none");
        end
      end
      if (c == rst_c) begin
        rst = 1'b1;
        #1 chk("ready_in_rst", 16'(ready), 16'd0);
        @(negedge clk);
        chk("bus_after_rst", bus_obs(), {1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00});
        chk("rsp_after_rst", 16'(rsp_valid), 16'd0);
        chk("rdata_after_rst", 16'(rdata), 16'd0);
        rst = 1'b0; gnt = 1'b0; badd_in = 8'h3F;
        void'(sb_q.pop_back());
        last_rd = 8'h00;
        #1 chk("ready_post_rst", 16'(ready), 16'd1);
        @(negedge clk);
        return;
      end
      gnt     = (c >= g) && (c <= ge);
      badd_in = (!w && strobe) ? rv : 8'h3F;
      if (c < idle_c) @(negedge clk);
    end
    if (!w) last_rd = rv;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; wr = 1'b1; cs = 1'b1; addr = 8'h3C; wdata = 8'h5A;
    gnt = 1'b0; badd_in = 8'h3F;
    repeat (3) @(negedge clk);
    chk("rst_bus", bus_obs(), {1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00});
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_rsp", 16'(rsp_valid), 16'd0);
    chk("rst_rdata", 16'(rdata), 16'd0);
    rst = 1'b0; valid = 1'b0;
    #1 chk("ready_after_rst", 16'(ready), 16'd1);
    @(negedge clk);

    access(1'b1, 1'b1, 8'h3C, 8'h5A, 8'h00, 1, 0, 0);    // basic write
    access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1, 0, 0);    // basic read
    access(1'b1, 1'b0, 8'h77, 8'hC3, 8'h00, 1, 0, 0);    // read data held
    access(1'b0, 1'b1, 8'h42, 8'h00, 8'h96, 20, 0, 0);   // grant delay
    access(1'b1, 1'b1, 8'hE1, 8'h18, 8'h00, 1, -1, 0);   // grant lost mid-strobe
    access(1'b0, 1'b0, 8'h55, 8'h00, 8'h3C, 1, 3, 0);    // release waits on GNT
    access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1, 0, 7);    // reset mid-strobe
    access(1'b1, 1'b0, 8'h3C, 8'h5A, 8'h00, 1, 0, 0);    // fresh write
    access(1'b0, 1'b1, 8'hC7, 8'h00, 8'h69, 1, 0, 0);    // back-to-back read

    chk("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/falc56_bus_master.md
# falc56_bus_master

Single-requester FALC56 multiplexed-bus cycle generator. It accepts one register read or write command at a time and requests the FALC56 bus arbiter over the REQ/GNT pair. Once granted, it drives one complete ALE/CSn/RDn/WRn access sequence on its requester-side bus lanes, then returns read data and releases the bus. One instance sits in front of each arbiter port: wishbone, wishbone T2 and DMA0.

## Interface
Parameters:
- ALE_CYCLES, 2, ALE-high address phase length in clocks (1..15)
- STROBE_CYCLES, 4, RDn/WRn low phase length in clocks (1..15)
- HOLD_CYCLES, 1, post-strobe recovery length in clocks (1..15)

Ports:
- PHY_CLK33_I  in  1  single clock; all logic on rising edge
- PHY_RST_I  in  1  synchronous, active-high reset
- CMD_VALID_I  in  1  command present
- CMD_READY_O  out  1  command accepted when VALID&READY at an edge
- CMD_WR_I  in  1  1 = write, 0 = read
- CMD_CS_I  in  1  chip select index: 0 → CSn[0], 1 → CSn[1]
- CMD_ADDR_I  in  8  register address
- CMD_WDATA_I  in  8  write data
- RSP_VALID_O  out  1  one-cycle completion pulse (reads and writes)
- RSP_RDATA_O  out  8  captured read data, held until the next read completes
- F56_REQ_O  out  1  bus request to arbiter
- F56_GNT_I  in  1  bus grant from arbiter
- F56_BADD_O  out  8  multiplexed address/data out
- F56_BADD_DIR_O  out  1  1 = drive BADD, 0 = release (read)
- F56_BADD_I  in  8  BADD pad input (read data)
- F56_ALE_O  out  1  address latch enable, active high
- F56_RDn_O, F56_WRn_O  out  1 each  strobes, active low
- F56_CSn_O  out  2  chip selects, active low

## Operation
- Idle bus values: BADD=0, DIR=0, ALE=0, RDn=1, WRn=1, CSn=2'b11, REQ=0.
- All bus outputs and REQ are registered.
- Reset drives these idle values, RSP_VALID=0, RSP_RDATA=0 and state IDLE. CMD_READY_O=0 while reset is asserted.
- On acceptance, CMD_WR, CMD_CS, CMD_ADDR and CMD_WDATA are latched. Later input changes are ignored.
- One 4-bit phase counter; each phase runs exactly its parameter count.
- States:
  - IDLE: READY=1. On acceptance → REQ.
  - REQ: REQ=1, bus idle. On an edge with GNT_I=1 → ADDR. Waits indefinitely otherwise.
  - ADDR (ALE_CYCLES): ALE=1, BADD=addr, DIR=1, CSn=11.
  - SETUP (1 cycle): ALE=0, BADD=addr, DIR=1.
  - STROBE (STROBE_CYCLES): CSn[cs]=0, other CSn bit=1. For a write: WRn=0, BADD=wdata, DIR=1. For a read: RDn=0, DIR=0, BADD=0. Read data is sampled from F56_BADD_I at the edge ending the last STROBE cycle.
  - RECOVER (HOLD_CYCLES): RDn=WRn=1, CSn=11. A write keeps BADD=wdata with DIR=1. A read keeps DIR=0.
  - RELEASE: REQ=0, bus idle, RSP_VALID=1 in the first RELEASE cycle only. Goes to IDLE on an edge with GNT_I=0. Minimum dwell is 1 cycle.
- REQ stays high from REQ through RECOVER.
- Once ADDR is entered the access completes unchanged even if GNT_I drops. The arbiter never switches away while REQ is high.
- RELEASE guarantees REQ low for at least 1 cycle between accesses, so the arbiter can re-arbitrate.
- Reset asserted in any state aborts the access: idle values at the next edge, no RSP_VALID pulse.

## Timing
- Cycle n means the cycle after the nth edge following acceptance (acceptance edge = edge 0).
- REQ is high from cycle 1. With the arbiter's registered grant, GNT_I is high in cycle 2.
- ADDR occupies cycles 3..2+A, SETUP cycle 3+A, STROBE 4+A..3+A+S, RECOVER 4+A+S..3+A+S+H.
- RELEASE and RSP_VALID occur in cycle 4+A+S+H. With defaults (A=2, S=4, H=1) this is cycle 11.
- Each extra cycle of GNT delay adds exactly one cycle.
- Next acceptance is possible no earlier than cycle 6+A+S+H (RELEASE, then IDLE).
- RSP_RDATA_O is valid in the RSP_VALID cycle.

## Test plan
- Reset: assert PHY_RST_I with a command pending → CSn=11, RDn=WRn=1, ALE=0, DIR=0, REQ=0, READY=0. After release READY=1.
- Write: addr 0x3C, data 0x5A, CS=1, GNT one cycle after REQ → ALE=1 with BADD=0x3C DIR=1 in cycles 3–4. CSn=2'b01 and WRn=0 with BADD=0x5A in cycles 6–9. RDn stays 1. RSP_VALID in cycle 11, REQ=0 in cycle 11.
- Read: addr 0x10, CS=0, bench drives F56_BADD_I=0xA5 in cycles 6–9 → DIR=0 and RDn=0 in cycles 6–9, CSn=2'b10. RSP_VALID in cycle 11 with RSP_RDATA=0xA5, held through a following write.
- Grant delay: GNT withheld 20 cycles → REQ=1, bus idle throughout. ALE rises on the edge after GNT is sampled high. Total latency grows by 19 cycles.
- Grant loss: drop GNT in the second STROBE cycle → STROBE, RECOVER and RSP_VALID timing unchanged. RELEASE exits only once GNT=0.
- Reset mid-STROBE of a read → idle values and REQ=0 at the next edge, no RSP_VALID. A fresh write accepted after reset completes normally. A back-to-back command shows REQ low for at least 1 cycle between accesses.
